cva6_l15_req_adapter: RTL and testbench
=======================================

CVA6_L15_REQ_ADAPTER -- requirements
Module: cva6_l15_req_adapter

Interface
REQ-001 Param MemTidWidth, default 2: transaction-ID width for both sources.
REQ-002 Param MaxOutstanding, default 4: per-source outstanding-request limit, range 1..7.
REQ-003 Param PAddrWidth, default 40: L1.5 physical address width.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 icache_req_valid_i / icache_req_ready_o  in/out  1/1  icache miss request handshake.
REQ-007 icache_req_paddr_i  in  PAddrWidth  line address; icache_req_nc_i  in  1  non-cacheable; icache_req_tid_i  in  MemTidWidth  ID.
REQ-008 dcache_req_valid_i / dcache_req_ready_o  in/out  1/1  dcache request handshake.
REQ-009 dcache_req_rtype_i  in  2  00 load, 01 store, 10 AMO; 11 reserved.
REQ-010 dcache_req_paddr_i  in  PAddrWidth; dcache_req_size_i  in  3; dcache_req_data_i  in  64  little-endian; dcache_req_nc_i  in  1; dcache_req_tid_i  in  MemTidWidth.
REQ-011 l15_val_o  out  1  request valid; l15_ack_i  in  1  L1.5 accepted request.
REQ-012 l15_rqtype_o  out  5; l15_address_o  out  PAddrWidth; l15_size_o  out  3; l15_data_o  out  64  big-endian; l15_nc_o  out  1; l15_tid_o  out  MemTidWidth; l15_src_o  out  1  (0 icache, 1 dcache).
REQ-013 l15_rtrn_val_i  in  1  response returned; l15_rtrn_src_i  in  1  source of that response.

Function
REQ-014 FSM states IDLE, SEND; IDLE->SEND on any accept; SEND->IDLE in the cycle after l15_ack_i=1 sampled in SEND.
REQ-015 ready_o of a source SHALL be 1 only in IDLE, when that source is granted, and its outstanding count < MaxOutstanding.
REQ-016 Arbitration round-robin: if both eligible, grant the source not granted last; single eligible source granted directly; last-grant pointer updates only on accept.
REQ-017 Accepted request registered; l15_val_o=1 from the cycle after accept until and including the ack cycle; all l15_* payload outputs stable while l15_val_o=1.
REQ-018 Minimum spacing: accept at N, ack at N+1 -> next accept no earlier than N+2.
REQ-019 rqtype mapping: icache -> IMISS 5'b10000; load -> 5'b00000; store -> 5'b00001; AMO -> 5'b00110; icache l15_size_o = 3'b111 (line).
REQ-020 l15_data_o = byte-reversed dcache_req_data_i (byte0 -> bits 63:56); icache requests drive data 0.
REQ-021 rtype 11 SHALL be accepted and dropped (no l15_val_o, no counter change).
REQ-022 Per-source outstanding counter +1 on ack, -1 on l15_rtrn_val_i for that source; simultaneous ack and return on same source: unchanged.
REQ-023 Return with counter 0 SHALL be ignored (no underflow); counter never exceeds MaxOutstanding.

Reset
REQ-024 On rst_ni=0: FSM IDLE, counters 0, last-grant=dcache (icache wins first tie), l15_val_o=0, all l15_* payload outputs 0, ready_o outputs 0 during reset.
REQ-025 Reset asserted mid-SEND SHALL drop l15_val_o asynchronously; in-flight request lost.

Structure
REQ-026 rqtype constants and the 2-bit dcache rtype enum SHALL live in the shared L1.5 package (wt_cache_pkg).
REQ-027 Round-robin arbiter is the natural sub-module: cva6_l15_rr_arb (2 requesters, grant + pointer).
REQ-028 No other sub-modules; byte-swap is combinational on the registered data.

Verification
REQ-029 Both sources valid after reset, ack after 1 cycle each -> icache then dcache granted, rqtype 10000 then 00000.
REQ-030 Store data 64'h0011223344556677 -> l15_data_o 64'h7766554433221100, rqtype 00001, held 5 cycles until ack.
REQ-031 Four icache requests acked, no returns (MaxOutstanding=4) -> icache_req_ready_o=0; one return -> ready reasserts.
REQ-032 Ack and rtrn on dcache same cycle with count 2 -> count stays 2.
REQ-033 rst_ni pulsed low while l15_val_o=1 -> l15_val_o=0 immediately, counters 0, icache wins next tie.
REQ-034 rtype 11 presented -> ready=1, no l15_val_o, next request accepted following cycle.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared L1.5 definitions: request-type encodings, dcache request kinds,
// source IDs and the adapter state encoding used by the request adapter.
package wt_cache_pkg;

  localparam logic [4:0] L15_IMISS_RQ = 5'b10000;
  localparam logic [4:0] L15_LOAD_RQ  = 5'b00000;
  localparam logic [4:0] L15_STORE_RQ = 5'b00001;
  localparam logic [4:0] L15_ATOMIC_RQ = 5'b00110;

  localparam logic [2:0] L15_LINE_SIZE = 3'b111;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ  = 2'b00,
    DCACHE_STORE_REQ = 2'b01,
    DCACHE_AMO_REQ   = 2'b10,
    DCACHE_RSVD_REQ  = 2'b11
  } dcache_rtype_e;

  typedef enum logic {
    L15_SRC_ICACHE = 1'b0,
    L15_SRC_DCACHE = 1'b1
  } l15_src_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } adapter_state_e;

  // The dcache hands us little-endian data; the L1.5 expects byte 0 in the MSBs.
  function automatic logic [63:0] swap_bytes64(input logic [63:0] d);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[63-8*i -: 8] = d[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [4:0] dcache_rqtype(input dcache_rtype_e t);
    logic [4:0] rq;
    case (t)
      DCACHE_STORE_REQ: rq = L15_STORE_RQ;
      DCACHE_AMO_REQ:   rq = L15_ATOMIC_RQ;
      default:          rq = L15_LOAD_RQ;
    endcase
    return rq;
  endfunction

endpackage

// File: rtl/cva6_l15_rr_arb.sv
// Two-requester round-robin arbiter; bit 0 is the icache, bit 1 the dcache.
// The last-grant pointer moves only when the granted request is accepted.
module cva6_l15_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic lastGnt_q, lastGnt_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = lastGnt_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    lastGnt_d = lastGnt_q;
    if (accept_i) begin
      lastGnt_d = gnt_o[1];
    end
  end

  // Reset to "dcache granted last" so the icache wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastGnt_q <= 1'b1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule

// File: rtl/cva6_l15_req_adapter.sv
// Merges icache and dcache miss requests onto the single L1.5 request port,
// one request in flight at a time, with per-source outstanding-request limits.
module cva6_l15_req_adapter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MemTidWidth    = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned PAddrWidth     = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   icache_req_valid_i,
  output logic                   icache_req_ready_o,
  input  logic [PAddrWidth-1:0]  icache_req_paddr_i,
  input  logic                   icache_req_nc_i,
  input  logic [MemTidWidth-1:0] icache_req_tid_i,

  input  logic                   dcache_req_valid_i,
  output logic                   dcache_req_ready_o,
  input  logic [1:0]             dcache_req_rtype_i,
  input  logic [PAddrWidth-1:0]  dcache_req_paddr_i,
  input  logic [2:0]             dcache_req_size_i,
  input  logic [63:0]            dcache_req_data_i,
  input  logic                   dcache_req_nc_i,
  input  logic [MemTidWidth-1:0] dcache_req_tid_i,

  output logic                   l15_val_o,
  input  logic                   l15_ack_i,
  output logic [4:0]             l15_rqtype_o,
  output logic [PAddrWidth-1:0]  l15_address_o,
  output logic [2:0]             l15_size_o,
  output logic [63:0]            l15_data_o,
  output logic                   l15_nc_o,
  output logic [MemTidWidth-1:0] l15_tid_o,
  output logic                   l15_src_o,

  input  logic                   l15_rtrn_val_i,
  input  logic                   l15_rtrn_src_i
);

  localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);

  adapter_state_e         state_q;
  logic                   val_q;
  logic [4:0]             rqtype_q;
  logic [PAddrWidth-1:0]  addr_q;
  logic [2:0]             size_q;
  logic [63:0]            data_q;
  logic                   nc_q;
  logic [MemTidWidth-1:0] tid_q;
  l15_src_e               src_q;

  logic [2:0] icCnt_q, icCnt_d;
  logic [2:0] dcCnt_q, dcCnt_d;

  logic       isIdle;
  logic       icElig, dcElig;
  logic [1:0] gnt;
  logic       icAcc, dcAcc;
  logic       dcRsvd;
  logic       ackDone;
  logic       icInc, icDec, dcInc, dcDec;

  assign isIdle = (state_q == IDLE);
  assign icElig = isIdle && icache_req_valid_i && (icCnt_q < MaxCnt);
  assign dcElig = isIdle && dcache_req_valid_i && (dcCnt_q < MaxCnt);

  cva6_l15_rr_arb i_rr_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    ({dcElig, icElig}),
    .accept_i (icAcc || dcAcc),
    .gnt_o    (gnt)
  );

  // Gating with rst_ni keeps both readies low for the whole reset window.
  assign icache_req_ready_o = rst_ni && isIdle && gnt[0] && (icCnt_q < MaxCnt);
  assign dcache_req_ready_o = rst_ni && isIdle && gnt[1] && (dcCnt_q < MaxCnt);

  assign icAcc  = icache_req_valid_i && icache_req_ready_o;
  assign dcAcc  = dcache_req_valid_i && dcache_req_ready_o;
  assign dcRsvd = (dcache_rtype_e'(dcache_req_rtype_i) == DCACHE_RSVD_REQ);

  // Reserved dcache requests are handshaken but never reach the L1.5.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      val_q    <= 1'b0;
      rqtype_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      nc_q     <= 1'b0;
      tid_q    <= '0;
      src_q    <= L15_SRC_ICACHE;
    end else begin
      case (state_q)
        IDLE: begin
          if (icAcc) begin
            state_q  <= SEND;
            val_q    <= 1'b1;
            rqtype_q <= L15_IMISS_RQ;
            addr_q   <= icache_req_paddr_i;
            size_q   <= L15_LINE_SIZE;
            data_q   <= '0;
            nc_q     <= icache_req_nc_i;
            tid_q    <= icache_req_tid_i;
            src_q    <= L15_SRC_ICACHE;
          end else if (dcAcc && !dcRsvd) begin
            state_q  <= SEND;
            val_q    <= 1'b1;
            rqtype_q <= dcache_rqtype(dcache_rtype_e'(dcache_req_rtype_i));
            addr_q   <= dcache_req_paddr_i;
            size_q   <= dcache_req_size_i;
            data_q   <= dcache_req_data_i;
            nc_q     <= dcache_req_nc_i;
            tid_q    <= dcache_req_tid_i;
            src_q    <= L15_SRC_DCACHE;
          end
        end
        SEND: begin
          if (l15_ack_i) begin
            state_q <= IDLE;
            val_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ackDone = (state_q == SEND) && l15_ack_i;
  assign icInc   = ackDone && (src_q == L15_SRC_ICACHE);
  assign dcInc   = ackDone && (src_q == L15_SRC_DCACHE);
  assign icDec   = l15_rtrn_val_i && !l15_rtrn_src_i && (icCnt_q != 3'd0);
  assign dcDec   = l15_rtrn_val_i &&  l15_rtrn_src_i && (dcCnt_q != 3'd0);

  // A return at zero is dropped by the Dec terms; ack plus return cancel out.
  always_comb begin
    icCnt_d = icCnt_q;
    if (icInc && !icDec && (icCnt_q < MaxCnt)) begin
      icCnt_d = icCnt_q + 3'd1;
    end else if (icDec && !icInc) begin
      icCnt_d = icCnt_q - 3'd1;
    end
  end

  always_comb begin
    dcCnt_d = dcCnt_q;
    if (dcInc && !dcDec && (dcCnt_q < MaxCnt)) begin
      dcCnt_d = dcCnt_q + 3'd1;
    end else if (dcDec && !dcInc) begin
      dcCnt_d = dcCnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icCnt_q <= 3'd0;
      dcCnt_q <= 3'd0;
    end else begin
      icCnt_q <= icCnt_d;
      dcCnt_q <= dcCnt_d;
    end
  end

  assign l15_val_o     = val_q;
  assign l15_rqtype_o  = rqtype_q;
  assign l15_address_o = addr_q;
  assign l15_size_o    = size_q;
  assign l15_data_o    = swap_bytes64(data_q);
  assign l15_nc_o      = nc_q;
  assign l15_tid_o     = tid_q;
  assign l15_src_o     = src_q;

endmodule

// File: tb/tb_cva6_l15_req_adapter.sv
// Directed bench for the L1.5 request adapter: arbitration, payload mapping,
// outstanding limits, reserved requests and asynchronous reset.
module tb_cva6_l15_req_adapter;

  localparam int unsigned MemTidWidth    = 2;
  localparam int unsigned MaxOutstanding = 4;
  localparam int unsigned PAddrWidth     = 40;

  logic                   clk = 1'b0;
  logic                   rstN = 1'b0;
  logic                   icValid = 1'b0;
  logic                   icReady;
  logic [PAddrWidth-1:0]  icPaddr = '0;
  logic                   icNc = 1'b0;
  logic [MemTidWidth-1:0] icTid = '0;
  logic                   dcValid = 1'b0;
  logic                   dcReady;
  logic [1:0]             dcRtype = 2'b00;
  logic [PAddrWidth-1:0]  dcPaddr = '0;
  logic [2:0]             dcSize = '0;
  logic [63:0]            dcData = '0;
  logic                   dcNc = 1'b0;
  logic [MemTidWidth-1:0] dcTid = '0;
  logic                   l15Val;
  logic                   ack = 1'b0;
  logic [4:0]             l15Rqtype;
  logic [PAddrWidth-1:0]  l15Address;
  logic [2:0]             l15Size;
  logic [63:0]            l15Data;
  logic                   l15Nc;
  logic [MemTidWidth-1:0] l15Tid;
  logic                   l15Src;
  logic                   rtrnVal = 1'b0;
  logic                   rtrnSrc = 1'b0;

  int compareCount  = 0;
  int mismatchCount = 0;

  cva6_l15_req_adapter #(
    .MemTidWidth    (MemTidWidth),
    .MaxOutstanding (MaxOutstanding),
    .PAddrWidth     (PAddrWidth)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .icache_req_valid_i (icValid),
    .icache_req_ready_o (icReady),
    .icache_req_paddr_i (icPaddr),
    .icache_req_nc_i    (icNc),
    .icache_req_tid_i   (icTid),
    .dcache_req_valid_i (dcValid),
    .dcache_req_ready_o (dcReady),
    .dcache_req_rtype_i (dcRtype),
    .dcache_req_paddr_i (dcPaddr),
    .dcache_req_size_i  (dcSize),
    .dcache_req_data_i  (dcData),
    .dcache_req_nc_i    (dcNc),
    .dcache_req_tid_i   (dcTid),
    .l15_val_o          (l15Val),
    .l15_ack_i          (ack),
    .l15_rqtype_o       (l15Rqtype),
    .l15_address_o      (l15Address),
    .l15_size_o         (l15Size),
    .l15_data_o         (l15Data),
    .l15_nc_o           (l15Nc),
    .l15_tid_o          (l15Tid),
    .l15_src_o          (l15Src),
    .l15_rtrn_val_i     (rtrnVal),
    .l15_rtrn_src_i     (rtrnSrc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rtype, input logic [39:0] paddr,
                               input logic [63:0] data, input logic [2:0] size,
                               input logic [1:0] tid);
    dcValid = 1'b1;
    dcRtype = rtype;
    dcPaddr = paddr;
    dcData  = data;
    dcSize  = size;
    dcTid   = tid;
    dcNc    = 1'b0;
  endtask

  // One dcache request: ready expected, accepted, acked on the first SEND cycle.
  task automatic dcTransaction(input string tag, input logic [1:0] rtype,
                               input logic [39:0] paddr, input logic [4:0] expRq);
    applyStimulus(rtype, paddr, 64'h0, 3'b011, 2'd0);
    settle();
    checkOutput({tag, " dc ready"}, 64'(dcReady), 64'd1);
    tick();
    dcValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput({tag, " val"}, 64'(l15Val), 64'd1);
    checkOutput({tag, " rqtype"}, 64'(l15Rqtype), 64'(expRq));
    tick();
    ack = 1'b0;
  endtask

  task automatic icTransaction(input string tag, input logic [39:0] paddr);
    icValid = 1'b1;
    icPaddr = paddr;
    settle();
    checkOutput({tag, " ic ready"}, 64'(icReady), 64'd1);
    tick();
    icValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput({tag, " val"}, 64'(l15Val), 64'd1);
    checkOutput({tag, " rqtype"}, 64'(l15Rqtype), 64'h10);
    checkOutput({tag, " src"}, 64'(l15Src), 64'd0);
    tick();
    ack = 1'b0;
  endtask

  initial begin
    // Reset state, with both sources already requesting.
    icValid = 1'b1;
    icPaddr = 40'h00_1000_0040;
    icTid   = 2'd1;
    applyStimulus(2'b00, 40'h00_2000_0008, 64'h0123456789abcdef, 3'b011, 2'd2);
    tick();
    tick();
    checkOutput("reset val", 64'(l15Val), 64'd0);
    checkOutput("reset ic ready", 64'(icReady), 64'd0);
    checkOutput("reset dc ready", 64'(dcReady), 64'd0);
    checkOutput("reset address", 64'(l15Address), 64'd0);
    checkOutput("reset data", l15Data, 64'd0);
    checkOutput("reset rqtype", 64'(l15Rqtype), 64'd0);
    rstN = 1'b1;
    settle();

    // First tie after reset goes to the icache.
    checkOutput("tie1 ic ready", 64'(icReady), 64'd1);
    checkOutput("tie1 dc ready", 64'(dcReady), 64'd0);
    tick();
    icValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput("imiss val", 64'(l15Val), 64'd1);
    checkOutput("imiss rqtype", 64'(l15Rqtype), 64'h10);
    checkOutput("imiss size", 64'(l15Size), 64'h7);
    checkOutput("imiss address", 64'(l15Address), 64'h00_1000_0040);
    checkOutput("imiss data", l15Data, 64'd0);
    checkOutput("imiss tid", 64'(l15Tid), 64'd1);
    checkOutput("imiss src", 64'(l15Src), 64'd0);
    checkOutput("send dc ready", 64'(dcReady), 64'd0);
    tick();
    ack = 1'b0;
    settle();
    checkOutput("idle val", 64'(l15Val), 64'd0);
    checkOutput("tie1 dc ready next", 64'(dcReady), 64'd1);
    tick();
    dcValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput("load val", 64'(l15Val), 64'd1);
    checkOutput("load rqtype", 64'(l15Rqtype), 64'h00);
    checkOutput("load src", 64'(l15Src), 64'd1);
    checkOutput("load size", 64'(l15Size), 64'h3);
    checkOutput("load tid", 64'(l15Tid), 64'd2);
    checkOutput("load data swap", l15Data, 64'hefcdab8967452301);
    tick();
    ack = 1'b0;
    settle();
    checkOutput("load done val", 64'(l15Val), 64'd0);

    // Store held for five cycles before the ack arrives.
    applyStimulus(2'b01, 40'h00_3000_0010, 64'h0011223344556677, 3'b011, 2'd3);
    settle();
    checkOutput("store dc ready", 64'(dcReady), 64'd1);
    tick();
    dcValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ack = 1'b1;
      settle();
      checkOutput("store held val", 64'(l15Val), 64'd1);
      checkOutput("store held data", l15Data, 64'h7766554433221100);
      checkOutput("store held rqtype", 64'(l15Rqtype), 64'h01);
      checkOutput("store held address", 64'(l15Address), 64'h00_3000_0010);
      tick();
    end
    ack = 1'b0;
    settle();
    checkOutput("store done val", 64'(l15Val), 64'd0);

    // dcache count is 2; ack and return together must leave it at 2.
    applyStimulus(2'b00, 40'h00_4000_0000, 64'h0, 3'b011, 2'd0);
    settle();
    checkOutput("simul dc ready", 64'(dcReady), 64'd1);
    tick();
    dcValid = 1'b0;
    ack = 1'b1;
    rtrnVal = 1'b1;
    rtrnSrc = 1'b1;
    settle();
    checkOutput("simul val", 64'(l15Val), 64'd1);
    tick();
    ack = 1'b0;
    rtrnVal = 1'b0;
    dcTransaction("dc cnt3", 2'b00, 40'h00_4000_0040, 5'b00000);
    dcTransaction("dc cnt4 amo", 2'b10, 40'h00_4000_0080, 5'b00110);
    dcValid = 1'b1;
    settle();
    checkOutput("dc full ready", 64'(dcReady), 64'd0);
    rtrnVal = 1'b1;
    rtrnSrc = 1'b1;
    tick();
    rtrnVal = 1'b0;
    settle();
    checkOutput("dc after return ready", 64'(dcReady), 64'd1);
    dcValid = 1'b0;

    // Drain dcache to zero, then one extra return that must not underflow.
    rtrnVal = 1'b1;
    rtrnSrc = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rtrnVal = 1'b0;
    dcValid = 1'b1;
    settle();
    checkOutput("dc no underflow ready", 64'(dcReady), 64'd1);
    dcValid = 1'b0;

    // icache: count 1 -> 0, then fill to the limit of 4.
    rtrnVal = 1'b1;
    rtrnSrc = 1'b0;
    tick();
    rtrnVal = 1'b0;
    for (int i = 0; i < 4; i++) icTransaction("ic fill", 40'h00_5000_0000 + 40'(i * 64));
    icValid = 1'b1;
    settle();
    checkOutput("ic full ready", 64'(icReady), 64'd0);
    rtrnVal = 1'b1;
    rtrnSrc = 1'b0;
    tick();
    rtrnVal = 1'b0;
    settle();
    checkOutput("ic after return ready", 64'(icReady), 64'd1);
    icValid = 1'b0;

    // icache was granted last, so the next tie goes to the dcache.
    icValid = 1'b1;
    applyStimulus(2'b00, 40'h00_6000_0000, 64'h0, 3'b011, 2'd0);
    settle();
    checkOutput("tie2 dc ready", 64'(dcReady), 64'd1);
    checkOutput("tie2 ic ready", 64'(icReady), 64'd0);
    tick();
    settle();
    checkOutput("pre reset val", 64'(l15Val), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("async reset val", 64'(l15Val), 64'd0);
    checkOutput("async reset address", 64'(l15Address), 64'd0);
    checkOutput("async reset ic ready", 64'(icReady), 64'd0);
    checkOutput("async reset dc ready", 64'(dcReady), 64'd0);
    tick();
    rstN = 1'b1;
    settle();
    checkOutput("tie3 ic ready", 64'(icReady), 64'd1);
    checkOutput("tie3 dc ready", 64'(dcReady), 64'd0);
    tick();
    icValid = 1'b0;
    dcValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput("tie3 src", 64'(l15Src), 64'd0);
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) icTransaction("ic post reset", 40'h00_7000_0000 + 40'(i * 64));
    icValid = 1'b1;
    settle();
    checkOutput("ic post reset full ready", 64'(icReady), 64'd0);
    icValid = 1'b0;

    // Reserved rtype is consumed silently; the next request goes straight in.
    applyStimulus(2'b11, 40'h00_8000_0000, 64'h0, 3'b011, 2'd0);
    settle();
    checkOutput("rsvd ready", 64'(dcReady), 64'd1);
    tick();
    dcRtype = 2'b00;
    dcPaddr = 40'h00_8000_0100;
    settle();
    checkOutput("rsvd no val", 64'(l15Val), 64'd0);
    checkOutput("after rsvd ready", 64'(dcReady), 64'd1);
    tick();
    dcValid = 1'b0;
    ack = 1'b1;
    settle();
    checkOutput("after rsvd val", 64'(l15Val), 64'd1);
    checkOutput("after rsvd address", 64'(l15Address), 64'h00_8000_0100);
    checkOutput("after rsvd rqtype", 64'(l15Rqtype), 64'h00);
    tick();
    ack = 1'b0;
    settle();
    checkOutput("final idle val", 64'(l15Val), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
